// File: rtl/lcd_bus_responder.sv
// HD44780-style responder for the 4-bit LCD write bus: init recognition, nibble pairing, command decode,
// 80-byte DDRAM image, busy modelling and sticky error flags. Optional E/setup timing checks: LCD_RESPONDER_TIMING_CHECK_EN.
module lcd_bus_responder #(
    parameter int unsigned POWERON_CYCLES    = 750000,
    parameter int unsigned CMD_BUSY_CYCLES   = 2000,
    parameter int unsigned CLEAR_BUSY_CYCLES = 82000,
    parameter int unsigned MIN_E_HIGH        = 12,
    parameter int unsigned MIN_SETUP         = 2
) (
    input  logic       Clock,
    input  logic       Reset,
    input  logic       iLCD_Enabled,
    input  logic       iLCD_RegisterSelect,
    input  logic       iLCD_ReadWrite,
    input  logic [3:0] iLCD_Data,
    input  logic [6:0] iRdAddr,
    output logic [7:0] oRdData,
    output logic       oByteValid,
    output logic [7:0] oByte,
    output logic       oByteIsData,
    output logic       oInitDone,
    output logic       oDisplayOn,
    output logic [6:0] oCursorAddr,
    output logic       oBusy,
    output logic [3:0] oErrors
);

    localparam logic [1:0] ST_PWRON   = 2'd0;
    localparam logic [1:0] ST_INIT8   = 2'd1;
    localparam logic [1:0] ST_BYTE_HI = 2'd2;
    localparam logic [1:0] ST_BYTE_LO = 2'd3;

    localparam int unsigned PWR_W    = $clog2(POWERON_CYCLES + 2);
    localparam int unsigned BUSY_MAX = (CLEAR_BUSY_CYCLES > CMD_BUSY_CYCLES) ? CLEAR_BUSY_CYCLES : CMD_BUSY_CYCLES;
    localparam int unsigned BUSY_W   = $clog2(BUSY_MAX + 2);

    localparam logic [PWR_W-1:0]  PWR_LAST   = PWR_W'(POWERON_CYCLES);
    localparam logic [BUSY_W-1:0] CMD_LOAD   = BUSY_W'(CMD_BUSY_CYCLES);
    localparam logic [BUSY_W-1:0] CLEAR_LOAD = BUSY_W'(CLEAR_BUSY_CYCLES);

    // The clear sweep needs one cycle per cell, so the clear busy time must cover it; timing counters saturate at 8 bits.
    if (CLEAR_BUSY_CYCLES < 80 || MIN_E_HIGH > 254 || MIN_SETUP > 254) begin : g_param_check
        $error("lcd_bus_responder: illegal parameter combination");
    end

    function automatic logic addr_legal(input logic [6:0] a);
        return (a[5:0] <= 6'h27);
    endfunction

    function automatic logic [6:0] lin_index(input logic [6:0] a);
        return a[6] ? (7'({1'b0, a[5:0]}) + 7'd40) : a;
    endfunction

    function automatic logic [6:0] set_addr(input logic [6:0] a);
        if (a >= 7'h68)
            return 7'h00;
        if (a >= 7'h28 && a < 7'h40)
            return 7'h40;
        return a;
    endfunction

    function automatic logic [6:0] step_addr(input logic [6:0] a, input logic inc);
        if (inc) begin
            if (a == 7'h27) return 7'h40;
            if (a == 7'h67) return 7'h00;
            return a + 7'd1;
        end
        if (a == 7'h00) return 7'h67;
        if (a == 7'h40) return 7'h27;
        return a - 7'd1;
    endfunction

    logic [1:0]        state_q, state_d;
    logic [PWR_W-1:0]  pwr_cnt_q, pwr_cnt_d;
    logic [BUSY_W-1:0] busy_cnt_q, busy_cnt_d;
    logic              e_prev_q, rs_prev_q, rw_prev_q;
    logic [3:0]        db_prev_q;
    logic [3:0]        hi_nib_q, hi_nib_d;
    logic              byte_valid_q, byte_valid_d;
    logic [7:0]        byte_q, byte_d;
    logic              byte_is_data_q, byte_is_data_d;
    logic              init_done_q, init_done_d;
    logic              disp_on_q, disp_on_d;
    logic [6:0]        addr_q, addr_d;
    logic              incr_q, incr_d;
    logic [3:0]        err_q, err_d;
    logic              sweep_act_q, sweep_act_d;
    logic [6:0]        sweep_idx_q, sweep_idx_d;
    logic [7:0]        rd_data_q, rd_data_d;
    logic [7:0]        ddram_q [0:79];

    logic       strobe, busy;
    logic       emit, emit_rs, decode, decode_data;
    logic [7:0] emit_byte;
    logic       mem_we;
    logic [6:0] mem_idx;
    logic [7:0] mem_wdata;

`ifdef LCD_RESPONDER_TIMING_CHECK_EN
    localparam logic [7:0] MIN_E_HIGH_C = 8'(MIN_E_HIGH);
    localparam logic [7:0] MIN_SETUP_C  = 8'(MIN_SETUP);
    logic [7:0] e_hi_cnt_q, e_hi_cnt_d;
    logic [7:0] stable_cnt_q, stable_cnt_d;
`endif

    assign strobe = e_prev_q & ~iLCD_Enabled;
    assign busy   = (busy_cnt_q != '0);

    always_comb begin
        state_d        = state_q;
        pwr_cnt_d      = pwr_cnt_q;
        busy_cnt_d     = busy ? (busy_cnt_q - BUSY_W'(1)) : busy_cnt_q;
        hi_nib_d       = hi_nib_q;
        byte_valid_d   = 1'b0;
        byte_d         = byte_q;
        byte_is_data_d = byte_is_data_q;
        init_done_d    = init_done_q;
        disp_on_d      = disp_on_q;
        addr_d         = addr_q;
        incr_d         = incr_q;
        err_d          = err_q;
        sweep_act_d    = sweep_act_q;
        sweep_idx_d    = sweep_idx_q;
        emit           = 1'b0;
        emit_rs        = 1'b0;
        emit_byte      = 8'h00;
        decode         = 1'b0;
        decode_data    = 1'b0;
        mem_we         = 1'b0;
        mem_idx        = sweep_idx_q;
        mem_wdata      = 8'h20;
        rd_data_d      = addr_legal(iRdAddr) ? ddram_q[lin_index(iRdAddr)] : 8'h20;

        if (state_q == ST_PWRON) begin
            if (pwr_cnt_q == PWR_LAST)
                state_d = ST_INIT8;
            else
                pwr_cnt_d = pwr_cnt_q + PWR_W'(1);
        end

        if (sweep_act_q) begin
            mem_we = 1'b1;
            if (sweep_idx_q == 7'd79)
                sweep_act_d = 1'b0;
            else
                sweep_idx_d = sweep_idx_q + 7'd1;
        end

        // Read strobes are rejected outright so the nibble phase stays where it was.
        if (strobe) begin
            if (rw_prev_q) begin
                err_d[2] = 1'b1;
            end else begin
                if (busy)
                    err_d[0] = 1'b1;
                case (state_q)
                    ST_PWRON: err_d[1] = 1'b1;
                    ST_INIT8: begin
                        emit      = 1'b1;
                        emit_byte = {db_prev_q, 4'h0};
                        emit_rs   = rs_prev_q;
                        if (db_prev_q == 4'h2) begin
                            state_d     = ST_BYTE_HI;
                            init_done_d = 1'b1;
                        end else if (db_prev_q != 4'h3) begin
                            decode = 1'b1;
                        end
                    end
                    ST_BYTE_HI: begin
                        hi_nib_d = db_prev_q;
                        state_d  = ST_BYTE_LO;
                    end
                    default: begin
                        emit        = 1'b1;
                        emit_byte   = {hi_nib_q, db_prev_q};
                        emit_rs     = rs_prev_q;
                        decode      = 1'b1;
                        decode_data = rs_prev_q;
                        state_d     = ST_BYTE_HI;
                    end
                endcase
            end
        end

        if (emit) begin
            byte_valid_d   = 1'b1;
            byte_d         = emit_byte;
            byte_is_data_d = emit_rs;
            busy_cnt_d     = CMD_LOAD;
        end

        if (decode) begin
            if (decode_data) begin
                mem_we      = 1'b1;
                mem_idx     = lin_index(addr_q);
                mem_wdata   = emit_byte;
                addr_d      = step_addr(addr_q, incr_q);
                sweep_act_d = 1'b0;
            end else if (emit_byte[7]) begin
                addr_d = set_addr(emit_byte[6:0]);
            end else if (emit_byte == 8'h01) begin
                sweep_act_d = 1'b1;
                sweep_idx_d = 7'd0;
                addr_d      = 7'h00;
                incr_d      = 1'b1;
                busy_cnt_d  = CLEAR_LOAD;
            end else if (emit_byte[7:1] == 7'h01) begin
                addr_d     = 7'h00;
                busy_cnt_d = CLEAR_LOAD;
            end else if (emit_byte[7:2] == 6'h01) begin
                incr_d = emit_byte[1];
            end else if (emit_byte[7:3] == 5'h01) begin
                disp_on_d = emit_byte[2];
            end
        end

`ifdef LCD_RESPONDER_TIMING_CHECK_EN
        e_hi_cnt_d   = iLCD_Enabled ? ((e_hi_cnt_q == 8'hFF) ? e_hi_cnt_q : e_hi_cnt_q + 8'd1) : 8'd0;
        stable_cnt_d = ({iLCD_RegisterSelect, iLCD_Data} != {rs_prev_q, db_prev_q}) ? 8'd0 :
                       ((stable_cnt_q == 8'hFF) ? stable_cnt_q : stable_cnt_q + 8'd1);
        if (strobe && e_hi_cnt_q < MIN_E_HIGH_C)
            err_d[3] = 1'b1;
        if (iLCD_Enabled && !e_prev_q && stable_cnt_q < MIN_SETUP_C)
            err_d[3] = 1'b1;
`else
        err_d[3] = 1'b0;
`endif
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            state_q        <= ST_PWRON;
            pwr_cnt_q      <= '0;
            busy_cnt_q     <= '0;
            e_prev_q       <= 1'b0;
            rs_prev_q      <= 1'b0;
            rw_prev_q      <= 1'b0;
            db_prev_q      <= 4'h0;
            hi_nib_q       <= 4'h0;
            byte_valid_q   <= 1'b0;
            byte_q         <= 8'h00;
            byte_is_data_q <= 1'b0;
            init_done_q    <= 1'b0;
            disp_on_q      <= 1'b0;
            addr_q         <= 7'h00;
            incr_q         <= 1'b1;
            err_q          <= 4'h0;
            sweep_act_q    <= 1'b0;
            sweep_idx_q    <= 7'd0;
            rd_data_q      <= 8'h00;
        end else begin
            state_q        <= state_d;
            pwr_cnt_q      <= pwr_cnt_d;
            busy_cnt_q     <= busy_cnt_d;
            e_prev_q       <= iLCD_Enabled;
            rs_prev_q      <= iLCD_RegisterSelect;
            rw_prev_q      <= iLCD_ReadWrite;
            db_prev_q      <= iLCD_Data;
            hi_nib_q       <= hi_nib_d;
            byte_valid_q   <= byte_valid_d;
            byte_q         <= byte_d;
            byte_is_data_q <= byte_is_data_d;
            init_done_q    <= init_done_d;
            disp_on_q      <= disp_on_d;
            addr_q         <= addr_d;
            incr_q         <= incr_d;
            err_q          <= err_d;
            sweep_act_q    <= sweep_act_d;
            sweep_idx_q    <= sweep_idx_d;
            rd_data_q      <= rd_data_d;
        end
    end

`ifdef LCD_RESPONDER_TIMING_CHECK_EN
    always_ff @(posedge Clock) begin
        if (Reset) begin
            e_hi_cnt_q   <= 8'd0;
            stable_cnt_q <= 8'd0;
        end else begin
            e_hi_cnt_q   <= e_hi_cnt_d;
            stable_cnt_q <= stable_cnt_d;
        end
    end
`endif

    // DDRAM contents survive reset, like the real controller.
    always_ff @(posedge Clock) begin
        if (mem_we && !Reset)
            ddram_q[mem_idx] <= mem_wdata;
    end

    assign oRdData     = rd_data_q;
    assign oByteValid  = byte_valid_q;
    assign oByte       = byte_q;
    assign oByteIsData = byte_is_data_q;
    assign oInitDone   = init_done_q;
    assign oDisplayOn  = disp_on_q;
    assign oCursorAddr = addr_q;
    assign oBusy       = busy;
    assign oErrors     = err_q;

endmodule
